// File: rtl/axi4_chan_slice.sv
// AXI4 single-channel buffer: FIFO slice or bypass, with handshake counters
// and a sticky upstream VALID/payload stability checker.
module axi4_chan_slice #(
  parameter int PAYLOAD_WIDTH = 64,
  parameter int DEPTH         = 2,
  parameter int MODE          = 1,
  parameter int COUNT_WIDTH   = 32
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [PAYLOAD_WIDTH-1:0]   s_payload,
  input  logic                       s_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [PAYLOAD_WIDTH-1:0]   m_payload,
  output logic                       m_last,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [COUNT_WIDTH-1:0]     beat_count,
  output logic [COUNT_WIDTH-1:0]     last_count,
  output logic                       stable_err
);

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (MODE == 0) begin : g_bypass
      assign m_valid   = s_valid;
      assign s_ready   = m_ready;
      assign m_payload = s_payload;
      assign m_last    = s_last;
      assign occupancy = '0;
    end else begin : g_fifo
      logic [PAYLOAD_WIDTH:0] mem_q [DEPTH];
      logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
      logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
      logic [OCC_W-1:0]       occ_q, occ_d;
      logic                   push, pop;

      // Flags come only from registered occupancy, so m_ready never reaches s_ready.
      assign s_ready   = (occ_q != OCC_W'(DEPTH));
      assign m_valid   = (occ_q != '0);
      assign m_payload = mem_q[rd_ptr_q][PAYLOAD_WIDTH-1:0];
      assign m_last    = mem_q[rd_ptr_q][PAYLOAD_WIDTH];
      assign occupancy = occ_q;

      always_comb begin
        push     = s_valid & s_ready;
        pop      = m_valid & m_ready;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      occ_d = occ_q + OCC_W'(1);
        else if (pop && !push) occ_d = occ_q - OCC_W'(1);
      end

      always_ff @(posedge aclk) begin
        if (areset) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          occ_q    <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          occ_q    <= occ_d;
        end
      end

      always_ff @(posedge aclk) begin
        if (push) mem_q[wr_ptr_q] <= {s_last, s_payload};
      end
    end
  endgenerate

  logic [COUNT_WIDTH-1:0]   beat_q, beat_d, last_q, last_d;
  logic                     stall_q, stall_d, err_q, err_d;
  logic [PAYLOAD_WIDTH-1:0] prev_payload_q;
  logic                     prev_last_q;

  always_comb begin
    beat_d  = beat_q;
    last_d  = last_q;
    stall_d = s_valid & ~s_ready;
    err_d   = err_q;
    if (m_valid && m_ready) begin
      beat_d = beat_q + COUNT_WIDTH'(1);
      if (m_last) last_d = last_q + COUNT_WIDTH'(1);
    end
    // A stalled beat must be re-presented unchanged in the next cycle.
    if (stall_q && (!s_valid || s_payload != prev_payload_q || s_last != prev_last_q))
      err_d = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      beat_q  <= '0;
      last_q  <= '0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      last_q  <= last_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
    prev_payload_q <= s_payload;
    prev_last_q    <= s_last;
  end

  assign beat_count = beat_q;
  assign last_count = last_q;
  assign stable_err = err_q;

endmodule

// File: tb/tb_axi4_chan_slice.sv
// Randomized + directed bench: a buffered slice (DEPTH 4) and a bypass slice
// (4-bit counters) checked every cycle against a queue-based reference model.
module tb_axi4_chan_slice;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        areset;
  // buffered instance
  logic        s_valid_a, s_ready_a, s_last_a, m_valid_a, m_ready_a, m_last_a, err_a;
  logic [15:0] s_payload_a, m_payload_a;
  logic [2:0]  occ_a;
  logic [31:0] beats_a, lasts_a;
  // bypass instance
  logic        s_valid_b, s_ready_b, s_last_b, m_valid_b, m_ready_b, m_last_b, err_b;
  logic [15:0] s_payload_b, m_payload_b;
  logic [1:0]  occ_b;
  logic [3:0]  beats_b, lasts_b;

  axi4_chan_slice #(.PAYLOAD_WIDTH(16), .DEPTH(4), .MODE(1), .COUNT_WIDTH(32)) dut_a (
    .aclk(clk), .areset(areset),
    .s_valid(s_valid_a), .s_ready(s_ready_a), .s_payload(s_payload_a), .s_last(s_last_a),
    .m_valid(m_valid_a), .m_ready(m_ready_a), .m_payload(m_payload_a), .m_last(m_last_a),
    .occupancy(occ_a), .beat_count(beats_a), .last_count(lasts_a), .stable_err(err_a));

  axi4_chan_slice #(.PAYLOAD_WIDTH(16), .DEPTH(2), .MODE(0), .COUNT_WIDTH(4)) dut_b (
    .aclk(clk), .areset(areset),
    .s_valid(s_valid_b), .s_ready(s_ready_b), .s_payload(s_payload_b), .s_last(s_last_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_payload(m_payload_b), .m_last(m_last_b),
    .occupancy(occ_b), .beat_count(beats_b), .last_count(lasts_b), .stable_err(err_b));

  int pass_cnt = 0;
  int total_cnt = 0;

  // reference model state
  logic [16:0] q_a[$];
  int unsigned mdl_beats_a = 0, mdl_lasts_a = 0;
  int unsigned mdl_beats_b = 0, mdl_lasts_b = 0;
  bit          mdl_err_a = 0, mdl_err_b = 0;
  bit          stall_prev_a = 0, stall_prev_b = 0;
  logic [16:0] prev_a, prev_b;
  bit          pushed_a;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    bit push_a, pop_a, pop_b, err_next_a, err_next_b;
    logic [16:0] head;
    @(negedge clk);
    check("a_occupancy", occ_a, q_a.size());
    check("a_s_ready", s_ready_a, q_a.size() != 4);
    check("a_m_valid", m_valid_a, q_a.size() != 0);
    if (q_a.size() != 0) check("a_head", {m_last_a, m_payload_a}, q_a[0]);
    check("a_beat_count", beats_a, mdl_beats_a);
    check("a_last_count", lasts_a, mdl_lasts_a);
    check("a_stable_err", err_a, mdl_err_a);
    check("b_m_valid", m_valid_b, s_valid_b);
    check("b_s_ready", s_ready_b, m_ready_b);
    check("b_data", {m_last_b, m_payload_b}, {s_last_b, s_payload_b});
    check("b_occupancy", occ_b, 0);
    check("b_beat_count", beats_b, mdl_beats_b);
    check("b_last_count", lasts_b, mdl_lasts_b);
    check("b_stable_err", err_b, mdl_err_b);

    push_a = s_valid_a && (q_a.size() < 4);
    pop_a  = m_ready_a && (q_a.size() > 0);
    pop_b  = s_valid_b && m_ready_b;
    err_next_a = mdl_err_a || (stall_prev_a &&
                 (!s_valid_a || {s_last_a, s_payload_a} != prev_a));
    err_next_b = mdl_err_b || (stall_prev_b &&
                 (!s_valid_b || {s_last_b, s_payload_b} != prev_b));
    @(posedge clk);
    pushed_a = push_a && !areset;
    if (areset) begin
      q_a.delete();
      mdl_beats_a = 0; mdl_lasts_a = 0; mdl_beats_b = 0; mdl_lasts_b = 0;
      mdl_err_a = 0; mdl_err_b = 0; stall_prev_a = 0; stall_prev_b = 0;
    end else begin
      if (pop_a) begin
        head = q_a.pop_front();
        mdl_beats_a++;
        if (head[16]) mdl_lasts_a++;
      end
      if (push_a) q_a.push_back({s_last_a, s_payload_a});
      if (pop_b) begin
        mdl_beats_b = (mdl_beats_b + 1) % 16;
        if (s_last_b) mdl_lasts_b = (mdl_lasts_b + 1) % 16;
      end
      mdl_err_a = err_next_a;
      mdl_err_b = err_next_b;
      stall_prev_a = s_valid_a && !push_a;
      stall_prev_b = s_valid_b && !m_ready_b;
    end
    prev_a = {s_last_a, s_payload_a};
    prev_b = {s_last_b, s_payload_b};
    #1;
  endtask

  task automatic drive_random();
    if (!stall_prev_a) begin
      s_valid_a   = ($urandom_range(0, 3) != 0);
      s_payload_a = 16'($urandom);
      s_last_a    = $urandom_range(0, 1) == 1;
    end
    m_ready_a = ($urandom_range(0, 2) != 0);
    if (!stall_prev_b) begin
      s_valid_b   = $urandom_range(0, 1) == 1;
      s_payload_b = 16'($urandom);
      s_last_b    = $urandom_range(0, 1) == 1;
    end
    m_ready_b = $urandom_range(0, 1) == 1;
  endtask

  initial begin
    areset = 1'b1;
    s_valid_a = 0; s_payload_a = 0; s_last_a = 0; m_ready_a = 0;
    s_valid_b = 0; s_payload_b = 0; s_last_b = 0; m_ready_b = 0;
    prev_a = '0; prev_b = '0;
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;

    // single beat on the buffer, 17 last-beats through the bypass
    s_valid_a = 1; s_payload_a = 16'h00A5; s_last_a = 1; m_ready_a = 1;
    s_valid_b = 1; m_ready_b = 1; s_last_b = 1;
    for (int i = 0; i < 17; i++) begin
      s_payload_b = 16'($urandom);
      step();
      s_valid_a = 0;
    end
    s_valid_b = 0;
    check("b_wrap_beats", beats_b, 1);
    check("b_wrap_lasts", lasts_b, 1);
    check("a_single_beats", beats_a, 1);
    check("a_single_lasts", lasts_a, 1);

    // fill to full with no drain, then hold beat 5 and drain
    m_ready_a = 0;
    for (int i = 1; i <= 4; i++) begin
      s_valid_a = 1; s_payload_a = 16'(i); s_last_a = (i == 4);
      step();
    end
    check("a_full_s_ready", s_ready_a, 0);
    check("a_full_occ", occ_a, 4);
    s_payload_a = 16'd5; s_last_a = 0; m_ready_a = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (pushed_a && s_payload_a == 16'd5) s_valid_a = 0;
    end

    // continuous streaming, 100 beats
    for (int i = 0; i < 100; i++) begin
      s_valid_a = 1; s_payload_a = 16'(16'h100 + i); s_last_a = (i % 10 == 9); m_ready_a = 1;
      step();
    end
    check("a_stream_occ", occ_a, 1);
    s_valid_a = 0;
    step();

    // random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      drive_random();
      step();
    end

    // stability violation: fill, stall 0x77, then change to 0x78
    s_valid_b = 0; m_ready_a = 0; s_last_a = 0;
    for (int i = 0; i < 8 && q_a.size() < 4; i++) begin
      s_valid_a = 1; s_payload_a = 16'($urandom);
      step();
    end
    s_payload_a = 16'h0077;
    step();
    s_payload_a = 16'h0078;
    step();
    step();
    check("a_err_set", err_a, 1);
    for (int i = 0; i < 20; i++) begin
      drive_random();
      step();
    end
    check("a_err_sticky", err_a, 1);
    areset = 1; step(); areset = 0;
    check("a_err_cleared", err_a, 0);

    // reset mid-burst with three entries held
    s_valid_a = 0; m_ready_a = 0; s_valid_b = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      s_valid_a = 1; s_payload_a = 16'(16'h0300 + i); s_last_a = 1;
      step();
    end
    check("a_pre_reset_occ", occ_a, 3);
    areset = 1; step(); areset = 0;
    s_valid_a = 0; m_ready_a = 1;
    check("a_post_reset_occ", occ_a, 0);
    check("a_post_reset_valid", m_valid_a, 0);
    check("a_post_reset_beats", beats_a, 0);
    check("a_post_reset_ready", s_ready_a, 1);
    repeat (4) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
